mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Two-requester arbiter that sits directly upstream of port A of the dual-port main-memory block RAM, sharing that single RAM port between two masters (e.g. CPU and loader/DMA). It grants one request per cycle with round-robin fairness, drives registered write-enable, address and data into the RAM, and returns read data to the correct requester with a valid strobe, accounting for the RAM's one-cycle registered read.

## Interface

Parameters:
- DATA, 18, data width; matches RAM word width
- ADDR, 14, address width; matches RAM address width

Ports:
- clka  in  1  system clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- req0  in  1  requester 0 request; held until ack0
- we0  in  1  requester 0: 1 = write, 0 = read
- addr0  in  ADDR  requester 0 address
- din0  in  DATA  requester 0 write data
- ack0  out  1  requester 0 granted this cycle (combinational)
- rvalid0  out  1  requester 0 read data valid on rdata0
- rdata0  out  DATA  requester 0 read data
- req1, we1, addr1, din1, ack1, rvalid1, rdata1: same as above for requester 1
- ram_we  out  1  to RAM wea
- ram_addr  out  ADDR  to RAM addra
- ram_din  out  DATA  to RAM dina
- ram_dout  in  DATA  from RAM douta

## Operation

- Arbitration (combinational, per cycle):
  - only req0 → ack0=1; only req1 → ack1=1; neither → no ack.
  - both → grant the port that is not last_grant; never both acks.
  - Never ack while rst_n=0.
- last_grant register: updated to the granted port on every grant; held otherwise; reset to 1 (port 0 wins the first contention).
- Issue stage (registered): on a grant in cycle N, ram_we/ram_addr/ram_din take the winner's we/addr/din at the end of N. With no grant, ram_we goes to 0 and ram_addr/ram_din hold their values.
- Tracking pipeline: 2-deep shift register of {valid_read, port_id}. Stage 1 is loaded on a grant with we=0; otherwise it is loaded with valid_read=0. Stage 2 follows stage 1.
- Return: rvalid0 = stage2.valid_read && id==0; rvalid1 = stage2.valid_read && id==1; rdata0 = rdata1 = ram_dout, which is meaningful only while the matching rvalid is high.
- Writes produce no response; ack is completion from the requester's view.
- After an ack, the requester may present a new request or drop req in the next cycle.
- Reset (rst_n=0 at an edge): ram_we=0, ram_addr=0, ram_din=0, both pipeline stages invalid, rvalid0=rvalid1=0, last_grant=1. In-flight reads are discarded; no rvalid is produced for any request acked before reset.

## Timing

- Ack: same cycle as the request when granted.
- Write: ack in cycle N → ram_we=1 in cycle N+1 → RAM updated at the end of N+1.
- Read: ack in cycle N → ram_addr valid in N+1 → RAM samples at the end of N+1 → rvalid and rdata valid in N+2. Fixed 2-cycle latency.
- Throughput: one access per cycle, sustained. With both ports continuously requesting, grants strictly alternate 0,1,0,1…
- Ordering: accesses reach the RAM in ack order. A write acked in N followed by a read of the same address acked in N+1 returns the new data.
- A read acked in the same cycle that rst_n is deasserted is valid. A read acked in the cycle before reset asserts yields no rvalid.
- ram_dout can change every cycle; requesters must sample rdata only when rvalid is high.

## Test plan

- Reset: hold rst_n=0 for 2 cycles with req0=req1=1 → ack0=ack1=0, ram_we=0, ram_addr=0, rvalid0/1=0; on release, the first contended grant goes to port 0.
- Single write then read: port 0 writes 18'h2A5A5 to 14'h0123 (ack cycle N), then reads 14'h0123 (ack N+1) → ram_we=1 in N+1; rvalid0=1 with rdata0=18'h2A5A5 in N+3; rvalid1 stays 0.
- Contention fairness: req0 and req1 held high for 6 cycles, all reads → acks alternate 0,1,0,1,0,1; rvalid alternates accordingly starting 2 cycles after the first ack; no cycle has both acks.
- Back-to-back reads: port 1 reads addresses 0,1,2,3 (preloaded with 18'h00010..18'h00013) on consecutive cycles → rvalid1 high for 4 consecutive cycles returning those words in order.
- Reset mid-flight: port 0 read acked in cycle N, rst_n=0 in N+1 → no rvalid0 in N+2; all outputs at reset values.
- Idle hold: port 0 writes addr 14'h3FFF, then no requests for 3 cycles → ram_we=0 and ram_addr held at 14'h3FFF; no acks or rvalids.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing RAM port A between two requesters. Drives registered
// RAM commands and returns read data with a strobe after the 2-cycle RAM latency.
module mem_port_arbiter #(
  parameter int DATA = 18,
  parameter int ADDR = 14
) (
  input  logic            clka,
  input  logic            rst_n,
  input  logic            req0,
  input  logic            we0,
  input  logic [ADDR-1:0] addr0,
  input  logic [DATA-1:0] din0,
  output logic            ack0,
  output logic            rvalid0,
  output logic [DATA-1:0] rdata0,
  input  logic            req1,
  input  logic            we1,
  input  logic [ADDR-1:0] addr1,
  input  logic [DATA-1:0] din1,
  output logic            ack1,
  output logic            rvalid1,
  output logic [DATA-1:0] rdata1,
  output logic            ram_we,
  output logic [ADDR-1:0] ram_addr,
  output logic [DATA-1:0] ram_din,
  input  logic [DATA-1:0] ram_dout
);

  logic            last_grant_r;
  logic            grant_s;
  logic            sel_s;
  logic            win_we_s;
  logic [ADDR-1:0] win_addr_s;
  logic [DATA-1:0] win_din_s;
  logic            ram_we_r;
  logic [ADDR-1:0] ram_addr_r;
  logic [DATA-1:0] ram_din_r;
  logic            stg1_vld_r;
  logic            stg1_id_r;
  logic            rvalid0_r;
  logic            rvalid1_r;

  // Grant selection: a lone requester wins; contention goes to the port not granted last.
  always_comb begin
    grant_s = 1'b0;
    sel_s   = 1'b0;
    if (!rst_n) begin
      grant_s = 1'b0;
    end else if (req0 && req1) begin
      grant_s = 1'b1;
      sel_s   = ~last_grant_r;
    end else if (req0) begin
      grant_s = 1'b1;
      sel_s   = 1'b0;
    end else if (req1) begin
      grant_s = 1'b1;
      sel_s   = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
  end

  // Command mux selecting the winning requester's access.
  always_comb begin
    win_we_s   = we0;
    win_addr_s = addr0;
    win_din_s  = din0;
    if (sel_s) begin
      win_we_s   = we1;
      win_addr_s = addr1;
      win_din_s  = din1;
    end else begin
      win_we_s   = we0;
      win_addr_s = addr0;
      win_din_s  = din0;
    end
  end

  assign ack0 = grant_s & ~sel_s;
  assign ack1 = grant_s & sel_s;

  // Issue register, grant history and read-return tracker.
  // The second tracker stage is kept pre-decoded per port as the rvalid registers.
  always_ff @(posedge clka) begin
    if (!rst_n) begin
      last_grant_r <= 1'b1;
      ram_we_r     <= 1'b0;
      ram_addr_r   <= {ADDR{1'b0}};
      ram_din_r    <= {DATA{1'b0}};
      stg1_vld_r   <= 1'b0;
      stg1_id_r    <= 1'b0;
      rvalid0_r    <= 1'b0;
      rvalid1_r    <= 1'b0;
    end else begin
      if (grant_s) begin
        last_grant_r <= sel_s;
        ram_addr_r   <= win_addr_s;
        ram_din_r    <= win_din_s;
      end else begin
        last_grant_r <= last_grant_r;
        ram_addr_r   <= ram_addr_r;
        ram_din_r    <= ram_din_r;
      end
      ram_we_r   <= grant_s & win_we_s;
      stg1_vld_r <= grant_s & ~win_we_s;
      stg1_id_r  <= sel_s;
      rvalid0_r  <= stg1_vld_r & ~stg1_id_r;
      rvalid1_r  <= stg1_vld_r & stg1_id_r;
    end
  end

  assign ram_we   = ram_we_r;
  assign ram_addr = ram_addr_r;
  assign ram_din  = ram_din_r;
  assign rvalid0  = rvalid0_r;
  assign rvalid1  = rvalid1_r;
  assign rdata0   = ram_dout;
  assign rdata1   = ram_dout;

endmodule
